// File: rtl/uart_pkg.sv
// Shared types for the UART TX sharing logic.
package uart_pkg;
  `include "baud_setting.svh"

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam baud_set_t BAUD_RESET = baud_set_t'(0);
endpackage

// File: rtl/baud_setting.svh
// Baud rate selector shared by the UART blocks; reset value is the first member.
`ifndef BAUD_SETTING_SVH
`define BAUD_SETTING_SVH
typedef enum logic [2:0] {
  BAUD_115200,
  BAUD_57600,
  BAUD_38400,
  BAUD_19200,
  BAUD_9600
} baud_set_t;
`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching cyclically from last_grant+1.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int c;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last_grant) + i) % N;
      if (en && !found && req[IW'(c)]) begin
        found            = 1'b1;
        grant[IW'(c)]    = 1'b1;
        grant_idx        = IW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX controller between N_REQ byte producers with round-robin
// arbitration, a post-done gap cycle, idle-only baud latching and a watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 400000,
  localparam int GW            = $clog2(N_REQ),
  localparam int WDW           = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                             clk_16mhz,
  input  logic                             rstn,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]                 req_ready,
  input  baud_set_t                        baud_setting_in,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             tx_en,
  input  logic                             tx_done,
  output baud_set_t                        baud_setting_out,
  output logic                             busy,
  output logic [GW-1:0]                    grant_id,
  output logic                             timeout_err
);

  arb_state_t       state, next_state;
  logic [GW-1:0]    last_grant;
  logic [WDW-1:0]   wd;
  logic [N_REQ-1:0] arb_grant;
  logic [GW-1:0]    arb_idx;
  logic             arb_en;
  logic             accept;
  logic             wd_expired;

  // Gated by rstn so req_ready reads 0 while reset is held.
  assign arb_en     = (state == IDLE) && rstn;
  assign accept     = |arb_grant;
  assign wd_expired = (wd == WDW'(TIMEOUT_CYCLES - 1));

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_valid),
    .last_grant(last_grant),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = LAUNCH;
      LAUNCH:    next_state = WAIT_DONE;
      WAIT_DONE: if (tx_done || wd_expired) next_state = GAP;
      GAP:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_en     = (state == LAUNCH);
    busy      = (state != IDLE);
    req_ready = arb_grant;
  end

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) begin
      tx_data          <= '0;
      grant_id         <= '0;
      last_grant       <= GW'(N_REQ - 1);
      wd               <= '0;
      timeout_err      <= 1'b0;
      baud_setting_out <= BAUD_RESET;
    end else begin
      case (state)
        IDLE: begin
          baud_setting_out <= baud_setting_in;
          if (accept) begin
            tx_data    <= req_data[arb_idx];
            grant_id   <= arb_idx;
            last_grant <= arb_idx;
          end
        end
        LAUNCH: wd <= '0;
        WAIT_DONE: begin
          wd <= wd + WDW'(1);
          // A coincident tx_done means the byte made it; no abort recorded.
          if (!tx_done && wd_expired) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
